// File: rtl/sdram_cfg_pkg.sv
// Shared SDRAM frame-buffer config: word width, burst length, command encodings,
// plus the camera write feeder's packer-phase and frame-state encodings.
package sdram_cfg_pkg;

  localparam int WORD_W        = 16;
  localparam int BURST_LEN_DEF = 256;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_MRS = 4'b0000;

  typedef enum logic {PH_HI = 1'b0, PH_LO = 1'b1} pack_ph_e;
  typedef enum logic {F_WAIT = 1'b0, F_RUN = 1'b1} frame_st_e;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO with a registered head; a pushed word reaches o_dout one cycle later.
// Accepts a push when full only alongside a pop; pops on empty are ignored and the head holds.
module sync_fifo_fwft
  import sdram_cfg_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int DW    = WORD_W,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic [DW-1:0] i_din,
  input  logic          i_pop,
  output logic [DW-1:0] o_dout,
  output logic [AW:0]   o_level,
  output logic [AW:0]   o_level_nxt,
  output logic          o_full,
  output logic          o_empty
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW-1:0] w_rd_nxt;
  logic [AW:0]   r_cnt;
  logic [DW-1:0] r_dout;
  logic          w_push_ok, w_pop_ok;

  assign o_full    = (r_cnt == FULL_CNT);
  assign o_empty   = (r_cnt == '0);
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || i_pop);
  assign w_rd_nxt  = r_rd_ptr + AW'(w_pop_ok);

  always_comb begin
    o_level_nxt = r_cnt;
    case ({w_push_ok, w_pop_ok})
      2'b10:   o_level_nxt = r_cnt + 1'b1;
      2'b01:   o_level_nxt = r_cnt - 1'b1;
      default: o_level_nxt = r_cnt;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_dout   <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      r_rd_ptr <= w_rd_nxt;
      r_cnt    <= o_level_nxt;
      // The new head may be the word being written this very cycle.
      if (o_level_nxt != '0)
        r_dout <= (w_push_ok && (r_wr_ptr == w_rd_nxt)) ? i_din : r_mem[w_rd_nxt];
    end
  end

  assign o_dout  = r_dout;
  assign o_level = r_cnt;

endmodule

// File: rtl/cam_wr_feeder.sv
// Packs camera bytes into RGB565 words for the SDRAM write path; write_trig is 1 cycle after the BURST_LEN-th word.
// No backpressure to the camera: words arriving at a full FIFO are dropped and flag overflow. Option: FRAME_SYNC_EN.
module cam_wr_feeder
  import sdram_cfg_pkg::*;
#(
  parameter int DEPTH     = 512,
  parameter int BURST_LEN = BURST_LEN_DEF,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic              sysclk_100M,
  input  logic              rst_n,
  input  logic              cam_byte_vld,
  input  logic [7:0]        cam_byte,
  input  logic              cam_vsync,
  output logic              write_trig,
  input  logic              write_data_vld,
  output logic [WORD_W-1:0] w_dq,
  output logic [AW:0]       fill_level,
  output logic              overflow,
  output logic              frame_start
);

  localparam logic [AW:0] TRIG_LVL = (AW+1)'(BURST_LEN);

  pack_ph_e    r_ph, w_ph_nxt;
  logic [7:0]  r_hi;
  logic        w_byte_ok, w_flush, w_push;
  logic [AW:0] w_level_nxt;
  logic        w_full, w_empty, w_unused_empty;
  logic        r_trig, r_ovf;

`ifdef FRAME_SYNC_EN
  frame_st_e r_fst, w_fst_nxt;
  logic      r_vs_d, r_fstart;
  logic      w_vs_fall, w_vs_rise;

  assign w_vs_fall = r_vs_d && !cam_vsync;
  assign w_vs_rise = !r_vs_d && cam_vsync;

  always_comb begin
    w_fst_nxt = r_fst;
    w_byte_ok = 1'b0;
    w_flush   = 1'b0;
    if (w_vs_fall) begin
      w_fst_nxt = F_RUN;
    end else if (w_vs_rise) begin
      w_fst_nxt = F_WAIT;
      w_flush   = (r_fst == F_RUN);
    end else begin
      w_byte_ok = cam_byte_vld && (r_fst == F_RUN);
    end
  end

  always_ff @(posedge sysclk_100M or negedge rst_n) begin
    if (!rst_n) begin
      r_fst    <= F_WAIT;
      r_vs_d   <= 1'b0;
      r_fstart <= 1'b0;
    end else begin
      r_fst    <= w_fst_nxt;
      r_vs_d   <= cam_vsync;
      r_fstart <= w_vs_fall && (r_fst == F_WAIT);
    end
  end

  assign frame_start = r_fstart;
`else
  logic w_unused_vsync;
  assign w_unused_vsync = cam_vsync;
  assign w_byte_ok      = cam_byte_vld;
  assign w_flush        = 1'b0;
  assign frame_start    = 1'b0;
`endif

  always_comb begin
    w_ph_nxt = r_ph;
    w_push   = 1'b0;
    if (w_flush) begin
      w_ph_nxt = PH_HI;
    end else if (w_byte_ok) begin
      if (r_ph == PH_HI) begin
        w_ph_nxt = PH_LO;
      end else begin
        w_ph_nxt = PH_HI;
        w_push   = 1'b1;
      end
    end
  end

  always_ff @(posedge sysclk_100M or negedge rst_n) begin
    if (!rst_n) begin
      r_ph   <= PH_HI;
      r_hi   <= '0;
      r_trig <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_ph <= w_ph_nxt;
      if (w_byte_ok && (r_ph == PH_HI)) r_hi <= cam_byte;
      r_trig <= (w_level_nxt >= TRIG_LVL);
      if (w_push && w_full && !write_data_vld) r_ovf <= 1'b1;
    end
  end

  sync_fifo_fwft #(
    .DEPTH (DEPTH),
    .DW    (WORD_W)
  ) u_fifo (
    .i_clk       (sysclk_100M),
    .i_rst_n     (rst_n),
    .i_push      (w_push),
    .i_din       ({r_hi, cam_byte}),
    .i_pop       (write_data_vld),
    .o_dout      (w_dq),
    .o_level     (fill_level),
    .o_level_nxt (w_level_nxt),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  assign w_unused_empty = w_empty;
  assign write_trig     = r_trig;
  assign overflow       = r_ovf;

endmodule

// File: doc/cam_wr_feeder.md
# cam_wr_feeder

Single-clock write-side feeder for the SDRAM frame buffer. It packs camera bytes, already in the 100 MHz domain, into 16-bit RGB565 words and buffers them in a first-word-fall-through FIFO. It raises `write_trig` once a full SDRAM write burst is buffered, then serves words to the SDRAM write path on each `write_data_vld` pop. It sits directly upstream of the SDRAM arbiter's write port.

## Interface
Parameters:
- `DEPTH`, 512: FIFO depth in 16-bit words; a power of two, ≥ 2×`BURST_LEN`.
- `BURST_LEN`, 256: words per SDRAM write burst; `write_trig` threshold.
- `AW`, log2(`DEPTH`): FIFO pointer width (derived; do not override).

Ports (clock and reset first):
- `sysclk_100M`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cam_byte_vld`  in  1  one camera byte present this cycle.
- `cam_byte`  in  8  camera byte; high byte of each pixel arrives first.
- `cam_vsync`  in  1  camera frame sync, active-high; used only with `FRAME_SYNC_EN`.
- `write_trig`  out  1  registered; ≥ `BURST_LEN` words buffered.
- `write_data_vld`  in  1  pop strobe from the SDRAM write path.
- `w_dq`  out  16  FIFO head word (FWFT).
- `fill_level`  out  AW+1  registered word count, 0..`DEPTH`.
- `overflow`  out  1  sticky; a word was dropped because the FIFO was full.
- `frame_start`  out  1  one-cycle pulse at frame start; only with `FRAME_SYNC_EN`.

## Operation
- **Packer.** Two phases, `PH_HI` and `PH_LO`; reset state is `PH_HI`.
  - In `PH_HI`, a `cam_byte_vld` latches `hi_byte` and moves to `PH_LO`.
  - In `PH_LO`, a `cam_byte_vld` forms the word `{hi_byte, cam_byte}`, pushes it, and returns to `PH_HI`.
- **Push.** Accepted when `fill_level < DEPTH`, or when `fill_level == DEPTH` and `write_data_vld` is high the same cycle.
  - Otherwise the word is dropped and `overflow` is set. It stays set until reset.
- **Pop.** `write_data_vld` with `fill_level == 0` is ignored: no pointer change, `w_dq` holds.
- **Simultaneous push and pop.** Both happen; `fill_level` is unchanged.
- **Pointers.** `AW`-bit, natural wrap-around at `DEPTH`; the count is kept separately.
- **`write_trig`.** Registered `(next fill_level) ≥ BURST_LEN`.
  - The consumer pops at most `BURST_LEN` words per trig-initiated burst.
  - The block never relies on the consumer to detect empty.
- **Reset values.**
  - `write_trig`=0, `w_dq`=16'h0000, `fill_level`=0, `overflow`=0, `frame_start`=0.
  - Pointers are 0; the packer is in `PH_HI`.
- **Reset mid-operation.** Buffered data and any half-packed pixel are discarded immediately; there is no recovery of partial state.

## Timing
- **Push to head.** A word pushed into an empty FIFO appears on `w_dq` the cycle after the second byte is sampled.
- **Pop to next word.** After a pop, the next word appears on `w_dq` the following cycle, so the consumer may pop every cycle.
- **`fill_level` and `write_trig`.** Both update the cycle after the push or pop edge that changes the count.
- **Latency.** Second byte of the `BURST_LEN`-th word to `write_trig`=1 is 1 cycle.
- **Zero-gap bursts.** A sustained 1 pop/cycle burst of `BURST_LEN` words drains with no gap while `fill_level` ≥ `BURST_LEN` at burst start.

## Configuration
- **Macro:** `FRAME_SYNC_EN`.
- **Defined:** frame gating state machine with states `F_WAIT` and `F_RUN`.
  - `F_WAIT` is the state after reset; bytes are ignored in `F_WAIT`.
  - A `cam_vsync` falling edge (1→0, detected with one register) moves to `F_RUN` and pulses `frame_start` the next cycle.
  - A `cam_vsync` rising edge in `F_RUN` discards any latched `hi_byte`, forces `PH_HI`, and returns to `F_WAIT`.
  - Words already pushed are kept.
  - A byte coincident with a vsync edge is ignored.
- **Undefined:** the block starts in `F_RUN`-equivalent behaviour; `cam_vsync` is ignored and `frame_start` is tied 0.

## Structure
- **Shared package `sdram_cfg_pkg`** holds:
  - the word width (16) and `BURST_LEN` default, shared with the SDRAM write path;
  - the NOP/command encodings already in the config;
  - the packer phase and frame-state encodings.
- **Sub-module `sync_fifo_fwft`** (`DEPTH`, width 16) provides the FWFT storage, count and full/empty.
  - Packer, gating, trig and overflow logic stay in the top.

## Test plan
- **Basic pack.** Bytes A1,B2,C3,D4 with `cam_byte_vld` every cycle → FIFO holds 16'hA1B2 then 16'hC3D4; `fill_level`=2; `w_dq`=16'hA1B2 one cycle after B2.
- **Trig threshold.** Push 255 words → `write_trig`=0. Push the 256th → `write_trig`=1 one cycle later. Pop 256 back-to-back → words in order, `fill_level`=0, `write_trig` drops the cycle after the pop that brings the count below 256.
- **Full/overflow.**
  - Fill to 512, push one more → word dropped, `overflow`=1 and stays 1.
  - At 512, push and pop in the same cycle → accepted, `fill_level` stays 512.
- **Empty pop.** `write_data_vld` on an empty FIFO → `fill_level`=0, `w_dq` unchanged, no pointer move; the next push reads back correctly.
- **Frame gating (`FRAME_SYNC_EN`).**
  - Bytes before the first vsync fall → ignored.
  - Vsync fall → `frame_start` pulse.
  - Odd byte then vsync rise → half-pixel discarded; the next frame's first word is formed from fresh bytes.
- **Reset mid-burst.** Assert `rst_n`=0 during a pop burst → all outputs return to reset values asynchronously; after release, `fill_level`=0 and the packer is in `PH_HI`.
